// File: rtl/sys_peripheral_hub.sv
// sys_peripheral_hub: bridges the HBUS-side SP window to NUM_SLOTS peripheral slots.
// It decodes {slot ID, offset} and drives one-hot read/write strobes together with the
// shared raddr/waddr/wdata. The strobe is held until the selected slot acks. The hub
// then returns read data, or reports a decode error, as a one-cycle hb_ready pulse.
// Optional feature: define SP_HUB_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES strobe cycles without an ack. The abort is reported as an error.
module sys_peripheral_hub #(
    parameter int SP_ID_LEN      = 3,
    parameter int SP_OFFSET_LEN  = 2,
    parameter int NUM_SLOTS      = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            hb_req,
    input  logic                            hb_we,
    input  logic [SP_ID_LEN+SP_OFFSET_LEN-1:0] hb_addr,
    input  logic [DATA_WIDTH-1:0]           hb_wdata,
    output logic                            hb_ready,
    output logic                            hb_err,
    output logic [DATA_WIDTH-1:0]           hb_rdata,
    output logic [SP_OFFSET_LEN-1:0]        sp_raddr,
    output logic [SP_OFFSET_LEN-1:0]        sp_waddr,
    output logic [DATA_WIDTH-1:0]           sp_wdata,
    output logic [NUM_SLOTS-1:0]            sp_re,
    output logic [NUM_SLOTS-1:0]            sp_we,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] sp_rdata,
    input  logic [NUM_SLOTS-1:0]            sp_ack
);

    localparam int ADDR_W = SP_ID_LEN + SP_OFFSET_LEN;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic                     we_q;
    logic [SP_ID_LEN-1:0]     slot_q;
    logic [SP_ID_LEN-1:0]     req_id;
    logic [SP_OFFSET_LEN-1:0] req_off;
    logic                     accept;
    logic                     id_ok;
    logic                     ack_sel;
    logic                     timeout;
    logic [NUM_SLOTS-1:0]     slot_sel;
    logic [DATA_WIDTH-1:0]    rdata_sel;

    assign req_id  = hb_addr[ADDR_W-1:SP_OFFSET_LEN];
    assign req_off = hb_addr[SP_OFFSET_LEN-1:0];
    assign id_ok   = ({1'b0, req_id} < (SP_ID_LEN+1)'(NUM_SLOTS));
    // A request is taken only in IDLE and never during the completion pulse, so a
    // request still held high in the hb_ready cycle is dropped, not queued.
    assign accept  = (state == ST_IDLE) && hb_req && !hb_ready;

    // Decode the latched slot: one-hot select, the selected ack bit and its read data
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        slot_sel  = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == SP_ID_LEN'(i)) begin
                slot_sel[i] = 1'b1;
                ack_sel     = sp_ack[i];
                rdata_sel   = sp_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef SP_HUB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Count strobe cycles that passed without an ack; cleared whenever an access starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS && !ack_sel) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // The last allowed strobe cycle is the one seen with TIMEOUT_CYCLES-1 misses behind it
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples
        // pre-edge values, regardless of the order in which the processes are evaluated.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: an ack beats a timeout in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = id_ok ? ST_ACCESS : ST_ERROR;
            ST_ACCESS: begin
                if (ack_sel)      state_nxt = ST_IDLE;
                else if (timeout) state_nxt = ST_ERROR;
            end
            ST_ERROR:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobe outputs: the one-hot select is steered to the read or the write strobe while accessing
    always_comb begin
        sp_re = '0;
        sp_we = '0;
        if (state == ST_ACCESS) begin
            if (we_q) sp_we = slot_sel;
            else      sp_re = slot_sel;
        end
    end

    // Latch the request; only a decodable access updates the slot-side address/data lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            slot_q   <= '0;
            sp_raddr <= '0;
            sp_waddr <= '0;
            sp_wdata <= '0;
        end else if (accept && id_ok) begin
            we_q   <= hb_we;
            slot_q <= req_id;
            if (hb_we) begin
                sp_waddr <= req_off;
                sp_wdata <= hb_wdata;
            end else begin
                sp_raddr <= req_off;
            end
        end
    end

    // Completion: a one-cycle ready pulse; read data is held until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_ready <= 1'b0;
            hb_err   <= 1'b0;
            hb_rdata <= '0;
        end else begin
            hb_ready <= 1'b0;
            hb_err   <= 1'b0;
            if (state == ST_ACCESS && ack_sel) begin
                hb_ready <= 1'b1;
                if (!we_q) hb_rdata <= rdata_sel;
            end else if (state == ST_ERROR) begin
                hb_ready <= 1'b1;
                hb_err   <= 1'b1;
                hb_rdata <= '0;
            end
        end
    end

endmodule
